// File: rtl/lsu_mem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between the LSU lanes of a bundle.
// One access is outstanding at a time: the winner is latched, issued on the memory
// request handshake, and for loads the read data is passed back to the owning lane.
module lsu_mem_arbiter #(
  parameter int unsigned NUM_LANES = 2,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_LANES-1:0]        lane_req,
  input  logic [NUM_LANES-1:0]        lane_we,
  input  logic [2*NUM_LANES-1:0]      lane_size,
  input  logic [ADDR_W*NUM_LANES-1:0] lane_addr,
  input  logic [32*NUM_LANES-1:0]     lane_wdata,
  output logic [NUM_LANES-1:0]        lane_gnt,
  output logic [NUM_LANES-1:0]        lane_err,
  output logic [NUM_LANES-1:0]        lane_rvalid,
  output logic [31:0]                 lane_rdata,
  output logic                        mem_req,
  output logic                        mem_we,
  output logic [3:0]                  mem_be,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [31:0]                 mem_wdata,
  input  logic                        mem_gnt,
  input  logic                        mem_rvalid,
  input  logic [31:0]                 mem_rdata,
  output logic                        stall
);

  localparam int unsigned LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e                state_q, state_d;
  logic [LW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [LW-1:0]         idx_q, idx_d;
  logic                  we_q, we_d;
  logic [3:0]            be_q, be_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [NUM_LANES-1:0]  err_q, err_d;

  logic [NUM_LANES-1:0]  eligible;
  logic                  found;
  logic [LW-1:0]         win;
  logic [LW-1:0]         cand;
  logic                  win_we;
  logic [1:0]            win_size;
  logic [ADDR_W-1:0]     win_addr;
  logic [31:0]           win_wdata;
  logic                  win_legal;
  logic [3:0]            win_be;

  function automatic logic [LW-1:0] wrap_inc(input logic [LW-1:0] x);
    if (32'(x) >= NUM_LANES - 1) return '0;
    return x + LW'(1);
  endfunction

  // A lane whose error is being reported this cycle still holds lane_req; skip it so
  // the same rejected request is not arbitrated twice.
  assign eligible = lane_req & ~err_q;

  // Round-robin search: first eligible lane at or after rr_ptr, wrapping.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = rr_ptr_q;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      if (!found && eligible[cand]) begin
        found = 1'b1;
        win   = cand;
      end
      cand = wrap_inc(cand);
    end
  end

  assign win_we    = lane_we[win];
  assign win_size  = lane_size[2*win +: 2];
  assign win_addr  = lane_addr[ADDR_W*win +: ADDR_W];
  assign win_wdata = lane_wdata[32*win +: 32];

  // Alignment check and byte-enable generation for the winning lane.
  always_comb begin
    win_legal = 1'b0;
    win_be    = 4'b0000;
    unique case (win_size)
      2'd0: begin
        win_legal = 1'b1;
        win_be    = 4'b0001 << win_addr[1:0];
      end
      2'd1: begin
        win_legal = ~win_addr[0];
        win_be    = win_addr[1] ? 4'b1100 : 4'b0011;
      end
      2'd2: begin
        win_legal = (win_addr[1:0] == 2'b00);
        win_be    = 4'b1111;
      end
      default: begin
        win_legal = 1'b0;
        win_be    = 4'b0000;
      end
    endcase
  end

  // State and latched-access registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
      idx_q    <= '0;
      we_q     <= 1'b0;
      be_q     <= 4'b0000;
      addr_q   <= '0;
      wdata_q  <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      idx_q    <= idx_d;
      we_q     <= we_d;
      be_q     <= be_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
    end
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    idx_d       = idx_q;
    we_d        = we_q;
    be_d        = be_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    err_d       = '0;
    lane_gnt    = '0;
    lane_rvalid = '0;
    lane_rdata  = '0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_be      = 4'b0000;
    mem_addr    = '0;
    mem_wdata   = '0;

    unique case (state_q)
      StIdle: begin
        if (found) begin
          if (win_legal) begin
            idx_d   = win;
            we_d    = win_we;
            be_d    = win_be;
            addr_d  = win_addr;
            wdata_d = win_wdata;
            state_d = StReq;
          end else begin
            // Rejected without memory traffic; error pulse appears next cycle.
            err_d[win] = 1'b1;
            rr_ptr_d   = wrap_inc(win);
          end
        end
      end
      StReq: begin
        mem_req   = 1'b1;
        mem_we    = we_q;
        mem_be    = be_q;
        mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
        mem_wdata = wdata_q;
        if (mem_gnt) begin
          lane_gnt[idx_q] = 1'b1;
          rr_ptr_d        = wrap_inc(idx_q);
          state_d         = we_q ? StIdle : StWait;
        end
      end
      StWait: begin
        if (mem_rvalid) begin
          lane_rvalid[idx_q] = 1'b1;
          lane_rdata         = mem_rdata;
          state_d            = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign lane_err = err_q;
  assign stall    = |(lane_req & ~lane_gnt & ~lane_err);

endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// Bench for lsu_mem_arbiter: directed scenarios with literal expectations, then
// randomized lane/memory traffic, all checked every cycle against a transaction model.
module tb_lsu_mem_arbiter;

  localparam int NL = 2;
  localparam int AW = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NL-1:0]   lane_req = '0;
  logic [NL-1:0]   lane_we = '0;
  logic [2*NL-1:0] lane_size = '0;
  logic [AW*NL-1:0] lane_addr = '0;
  logic [32*NL-1:0] lane_wdata = '0;
  logic [NL-1:0]   lane_gnt, lane_err, lane_rvalid;
  logic [31:0]     lane_rdata;
  logic            mem_req, mem_we;
  logic [3:0]      mem_be;
  logic [AW-1:0]   mem_addr;
  logic [31:0]     mem_wdata;
  logic            mem_gnt = 1'b0;
  logic            mem_rvalid = 1'b0;
  logic [31:0]     mem_rdata = '0;
  logic            stall;

  int errors = 0;
  int checks = 0;

  lsu_mem_arbiter #(.NUM_LANES(NL), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .lane_req   (lane_req),
    .lane_we    (lane_we),
    .lane_size  (lane_size),
    .lane_addr  (lane_addr),
    .lane_wdata (lane_wdata),
    .lane_gnt   (lane_gnt),
    .lane_err   (lane_err),
    .lane_rvalid(lane_rvalid),
    .lane_rdata (lane_rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .stall      (stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Byte lanes touched by an access of 2**size bytes at byte offset off.
  function automatic logic [3:0] be_of(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] b = 4'b0000;
    int n = 1 << size;
    int o = int'(off);
    for (int k = 0; k < 4; k++) if (k >= o && k < o + n) b[k] = 1'b1;
    return b;
  endfunction

  function automatic bit legal_of(input logic [1:0] size, input logic [1:0] off);
    int o = int'(off);
    return (size != 2'd3) && ((o % (1 << size)) == 0);
  endfunction

  // Transaction model: phase 0 = free, 1 = access offered to memory, 2 = awaiting data.
  int          m_ph = 0;
  int          m_cur = 0;
  int          m_ptr = 0;
  int          m_err = -1;
  logic        m_we = 1'b0;
  logic [1:0]  m_size = 2'd0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_wdata = '0;
  logic [NL-1:0] e_gnt = '0;
  logic [NL-1:0] e_err = '0;

  always @(negedge clk) begin : model_chk
    logic [NL-1:0] eg, ee, erv;
    logic [31:0]   erd, ead, ewd;
    logic          ereq, ewe, est, found;
    logic [3:0]    ebe;
    int            nerr, l;
    logic [1:0]    sz;
    logic [31:0]   ad;
    if (!rst_n) begin
      m_ph = 0; m_cur = 0; m_ptr = 0; m_err = -1;
    end
    eg = '0; ee = '0; erv = '0; erd = '0; ereq = 1'b0; ewe = 1'b0;
    ebe = 4'b0000; ead = '0; ewd = '0;
    if (m_err >= 0) ee[m_err] = 1'b1;
    if (m_ph == 1) begin
      ereq = 1'b1; ewe = m_we; ebe = be_of(m_size, m_addr[1:0]);
      ead = {m_addr[31:2], 2'b00}; ewd = m_wdata; eg[m_cur] = mem_gnt;
    end
    if (m_ph == 2 && mem_rvalid) begin
      erv[m_cur] = 1'b1; erd = mem_rdata;
    end
    est = |(lane_req & ~eg & ~ee);
    chk("lane_gnt", lane_gnt, eg);
    chk("lane_err", lane_err, ee);
    chk("lane_rvalid", lane_rvalid, erv);
    chk("lane_rdata", lane_rdata, erd);
    chk("mem_req", mem_req, ereq);
    chk("mem_we", mem_we, ewe);
    chk("mem_be", mem_be, ebe);
    chk("mem_addr", mem_addr, ead);
    chk("mem_wdata", mem_wdata, ewd);
    chk("stall", stall, est);
    e_gnt = eg;
    e_err = ee;
    if (rst_n) begin
      nerr = -1;
      case (m_ph)
        1: if (mem_gnt) begin
          m_ptr = (m_cur + 1) % NL;
          m_ph  = m_we ? 0 : 2;
        end
        2: if (mem_rvalid) m_ph = 0;
        default: begin
          found = 1'b0;
          for (int k = 0; k < NL; k++) begin
            l = (m_ptr + k) % NL;
            if (!found && lane_req[l] && !ee[l]) begin
              found = 1'b1;
              sz = lane_size[2*l +: 2];
              ad = lane_addr[AW*l +: AW];
              if (legal_of(sz, ad[1:0])) begin
                m_ph = 1; m_cur = l; m_we = lane_we[l]; m_size = sz; m_addr = ad;
                m_wdata = lane_wdata[32*l +: 32];
              end else begin
                nerr  = l;
                m_ptr = (l + 1) % NL;
              end
            end
          end
        end
      endcase
      m_err = nerr;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic set_lane(input int l, input logic we, input logic [1:0] size,
                          input logic [31:0] addr, input logic [31:0] wdata);
    lane_we[l]             = we;
    lane_size[2*l +: 2]    = size;
    lane_addr[AW*l +: AW]  = addr;
    lane_wdata[32*l +: 32] = wdata;
  endtask

  // Both lanes load at once; `first` is the lane round-robin must serve first.
  task automatic pair(input int first);
    set_lane(0, 1'b0, 2'd2, 32'h40, 32'h0);
    set_lane(1, 1'b0, 2'd2, 32'h80, 32'h0);
    lane_req = 2'b11; mem_gnt = 1'b1; mem_rvalid = 1'b0;
    for (int n = 0; n < 2; n++) begin
      int l = (n == 0) ? first : 1 - first;
      mid();
      chk("pair idle no req", mem_req, 1'b0);
      cyc();
      mid();
      chk("pair gnt order", lane_gnt, 64'(1 << l));
      chk("pair addr", mem_addr, (l == 1) ? 32'h80 : 32'h40);
      cyc();
      lane_req[l] = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hA000 + 32'(l);
      mid();
      chk("pair rvalid", lane_rvalid, 64'(1 << l));
      chk("pair rdata", lane_rdata, 32'hA000 + 32'(l));
      cyc();
      mem_rvalid = 1'b0;
    end
    mem_gnt = 1'b0;
  endtask

  initial begin
    // Reset
    mid();
    chk("reset mem_req", mem_req, 1'b0);
    chk("reset lane_gnt", lane_gnt, 2'b00);
    chk("reset lane_rdata", lane_rdata, 32'h0);
    cyc();
    rst_n = 1'b1;

    // Word store from lane 0, memory grants immediately
    set_lane(0, 1'b1, 2'd2, 32'h100, 32'hDEADBEEF);
    lane_req = 2'b01; mem_gnt = 1'b1;
    mid();
    chk("t1 stall idle", stall, 1'b1);
    chk("t1 no mem_req yet", mem_req, 1'b0);
    cyc();
    mid();
    chk("t1 mem_req", mem_req, 1'b1);
    chk("t1 mem_be", mem_be, 4'hF);
    chk("t1 mem_addr", mem_addr, 32'h100);
    chk("t1 mem_wdata", mem_wdata, 32'hDEADBEEF);
    chk("t1 lane_gnt", lane_gnt, 2'b01);
    cyc();
    lane_req = 2'b00; mem_gnt = 1'b0;
    mid();
    chk("t1 stall after", stall, 1'b0);
    chk("t1 mem_req after", mem_req, 1'b0);

    // Lane 1 byte load at 0x203, grant delayed three cycles, data two cycles later
    cyc();
    set_lane(1, 1'b0, 2'd0, 32'h203, 32'h0);
    lane_req = 2'b10;
    mid();
    for (int i = 0; i < 4; i++) begin
      cyc();
      mem_gnt = (i == 3);
      mid();
      chk("t3 mem_req held", mem_req, 1'b1);
      chk("t3 mem_be", mem_be, 4'b1000);
      chk("t3 mem_addr", mem_addr, 32'h200);
      chk("t3 lane_gnt", lane_gnt, (i == 3) ? 2'b10 : 2'b00);
      chk("t3 stall", stall, (i == 3) ? 1'b0 : 1'b1);
    end
    cyc();
    lane_req = 2'b00; mem_gnt = 1'b0;
    mid();
    chk("t3 wait no rvalid", lane_rvalid, 2'b00);
    chk("t3 wait no req", mem_req, 1'b0);
    cyc();
    mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
    mid();
    chk("t3 lane_rvalid", lane_rvalid, 2'b10);
    chk("t3 lane_rdata", lane_rdata, 32'h12345678);
    cyc();
    mem_rvalid = 1'b0;

    // Simultaneous loads: pointer sits at lane 0 after lane 1 was served
    pair(0);
    pair(0);

    // Misaligned half and illegal size from lane 0
    set_lane(0, 1'b0, 2'd1, 32'h101, 32'h0);
    lane_req = 2'b01;
    mid();
    chk("t4 half no err yet", lane_err, 2'b00);
    cyc();
    mid();
    chk("t4 half lane_err", lane_err, 2'b01);
    chk("t4 half no mem_req", mem_req, 1'b0);
    chk("t4 half stall", stall, 1'b0);
    cyc();
    lane_req = 2'b00;
    mid();
    cyc();
    set_lane(0, 1'b0, 2'd3, 32'h100, 32'h0);
    lane_req = 2'b01;
    mid();
    cyc();
    mid();
    chk("t4 size3 lane_err", lane_err, 2'b01);
    chk("t4 size3 no mem_req", mem_req, 1'b0);
    cyc();
    lane_req = 2'b00;
    // Pointer advanced past lane 0, so lane 1 now wins the tie
    pair(1);

    // Reset during a pending load; the late data must be dropped
    set_lane(0, 1'b0, 2'd2, 32'h300, 32'h0);
    lane_req = 2'b01; mem_gnt = 1'b1;
    mid();
    cyc();
    mid();
    chk("t5 load gnt", lane_gnt, 2'b01);
    cyc();
    lane_req = 2'b00; mem_gnt = 1'b0;
    mid();
    cyc();
    rst_n = 1'b0;
    mid();
    chk("t5 reset mem_req", mem_req, 1'b0);
    chk("t5 reset rvalid", lane_rvalid, 2'b00);
    cyc();
    rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h55;
    mid();
    chk("t5 late rvalid ignored", lane_rvalid, 2'b00);
    chk("t5 late rdata ignored", lane_rdata, 32'h0);
    cyc();

    // Spurious memory responses while idle
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hBAD;
    mid();
    chk("t6 no lane_gnt", lane_gnt, 2'b00);
    chk("t6 no lane_rvalid", lane_rvalid, 2'b00);
    chk("t6 no mem_req", mem_req, 1'b0);
    cyc();
    mem_gnt = 1'b0; mem_rvalid = 1'b0;

    // Randomized traffic, checked by the model every cycle
    for (int c = 0; c < 4000; c++) begin
      cyc();
      for (int l = 0; l < NL; l++) begin
        if (lane_req[l]) begin
          if (e_gnt[l] || e_err[l]) lane_req[l] = 1'b0;
        end else if ($urandom_range(2) == 0) begin
          logic [31:0] a;
          a = $urandom;
          if ($urandom_range(1) == 0) a[1:0] = 2'b00;
          set_lane(l, 1'($urandom_range(1)), 2'($urandom_range(3)), a, $urandom);
          lane_req[l] = 1'b1;
        end
      end
      mem_gnt    = 1'($urandom_range(1));
      mem_rvalid = ($urandom_range(2) == 0);
      mem_rdata  = $urandom;
    end
    mid();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
